// File: rtl/ahbl_test_slave.sv
// ----------------------------------------------------------------------------
// ahbl_test_slave
//
// AHB-Lite memory slave for exercising bus masters. Every transfer can be
// given a programmable number of wait states and can be forced to end in an
// ERROR response. The slave holds one exclusive-access reservation, which is
// enough to exercise load-exclusive/store-exclusive sequences.
//
// Parameters
//   W_ADDR  address width
//   W_DATA  data width (only 32 is supported)
//   DEPTH   memory size in 32-bit words, power of two
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ahbls_hready        bus HREADY (end of the previous data phase)
//   ahbls_hready_resp   slave HREADYOUT
//   ahbls_hresp         1 = ERROR response
//   ahbls_hexokay       exclusive access succeeded
//   ahbls_haddr/hwrite/htrans/hsize/hexcl   address-phase controls
//   ahbls_hburst/hprot/hmastlock            present on the bus, not used
//   ahbls_hwdata        write data (data phase)
//   ahbls_hrdata        read data (zero outside a completing read)
//   cfg_stall           wait states for the transfer being accepted
//   cfg_err             force ERROR for the transfer being accepted
// ----------------------------------------------------------------------------
module ahbl_test_slave #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  output logic              ahbls_hexokay,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic              ahbls_hexcl,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  input  logic [3:0]        cfg_stall,
  input  logic              cfg_err
);

  localparam int W_IDX = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       dp_valid, dp_valid_nxt;

  // Address-phase information captured for the data phase in progress.
  logic [W_IDX-1:0] dp_idx;
  logic [1:0]       dp_lo;
  logic [1:0]       dp_size;
  logic             dp_write;
  logic             dp_excl;
  logic             dp_bad;

  logic [W_DATA-1:0] mem [DEPTH];

  logic             res_valid;
  logic [W_IDX-1:0] res_idx;

  logic       can_accept;
  logic       accept;
  logic       misaligned;
  logic       out_of_range;
  logic       req_bad;
  logic       complete;
  logic       excl_match;
  logic       do_write;
  logic [3:0] byte_en;

  // Burst, protection and lock carry no meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock};

  // A new address phase can only be taken in a cycle where this slave is
  // itself signalling ready, i.e. the last cycle of a data phase or idle.
  assign can_accept   = (state == S_IDLE) || (state == S_ERR2);
  assign accept       = can_accept && ahbls_hready && ahbls_htrans[1];
  assign out_of_range = (ahbls_haddr >> 2) >= W_ADDR'(DEPTH);
  assign req_bad      = cfg_err || (ahbls_hsize > 3'd2) || misaligned || out_of_range;

  // Alignment check for the sizes we support; larger sizes are already bad.
  always_comb begin
    misaligned = 1'b0;
    case (ahbls_hsize)
      3'd1:    misaligned = ahbls_haddr[0];
      3'd2:    misaligned = |ahbls_haddr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // State register. dp_valid marks that the next IDLE cycle is the completing
  // OKAY cycle of a transfer rather than a plain idle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      dp_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dp_valid <= dp_valid_nxt;
    end
  end

  // Next-state logic. cnt holds the wait cycles still to be spent in WAIT,
  // counting the current one, so WAIT lasts exactly cfg_stall cycles.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dp_valid_nxt = 1'b0;
    case (state)
      S_IDLE, S_ERR2: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (cfg_stall != 4'd0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = cfg_stall;
          end else if (req_bad) begin
            state_nxt = S_ERR1;
          end else begin
            dp_valid_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          if (dp_bad) begin
            state_nxt = S_ERR1;
          end else begin
            state_nxt    = S_IDLE;
            dp_valid_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs depend only on the state, so reset forces them at once.
  always_comb begin
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    case (state)
      S_WAIT: ahbls_hready_resp = 1'b0;
      S_ERR1: begin
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = 1'b1;
      end
      S_ERR2: ahbls_hresp = 1'b1;
      default: ;
    endcase
  end

  // Capture the address phase for use during the following data phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_idx   <= '0;
      dp_lo    <= 2'd0;
      dp_size  <= 2'd0;
      dp_write <= 1'b0;
      dp_excl  <= 1'b0;
      dp_bad   <= 1'b0;
    end else if (accept) begin
      dp_idx   <= ahbls_haddr[W_IDX+1:2];
      dp_lo    <= ahbls_haddr[1:0];
      dp_size  <= ahbls_hsize[1:0];
      dp_write <= ahbls_hwrite;
      dp_excl  <= ahbls_hexcl;
      dp_bad   <= req_bad;
    end
  end

  assign complete   = (state == S_IDLE) && dp_valid;
  assign excl_match = res_valid && (res_idx == dp_idx);
  // A failed store-exclusive completes OKAY but must leave memory untouched.
  assign do_write   = complete && dp_write && (!dp_excl || excl_match);

  assign ahbls_hexokay = complete && dp_excl && (!dp_write || excl_match);
  assign ahbls_hrdata  = (complete && !dp_write) ? mem[dp_idx] : '0;

  // Byte lanes written, from the captured size and low address bits.
  always_comb begin
    byte_en = 4'b0000;
    case (dp_size)
      2'd0:    byte_en = 4'b0001 << dp_lo;
      2'd1:    byte_en = dp_lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Memory array. Deliberately not reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[dp_idx][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
        end
      end
    end
  end

  // Exclusive reservation. Only OKAY completions touch it; ERROR-terminated
  // transfers never reach the completing cycle. A failed store-exclusive
  // leaves it as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_idx   <= '0;
    end else if (complete) begin
      if (dp_excl && !dp_write) begin
        res_valid <= 1'b1;
        res_idx   <= dp_idx;
      end else if (do_write && excl_match) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_test_slave.sv
// ----------------------------------------------------------------------------
// tb_ahbl_test_slave
//
// Directed bench for ahbl_test_slave. A transaction-level model predicts the
// response of every cycle from the transfers seen on the bus, and literal
// expectations in the stimulus sequence pin down key results.
// ----------------------------------------------------------------------------
module tb_ahbl_test_slave;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        hready_resp;
  logic        hresp;
  logic        hexokay;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hexcl;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic [3:0]  cfg_stall;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  // The slave is the only one on the bus, so HREADY is its own HREADYOUT.
  ahbl_test_slave #(
    .W_ADDR(32),
    .W_DATA(32),
    .DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ahbls_hready     (hready_resp),
    .ahbls_hready_resp(hready_resp),
    .ahbls_hresp      (hresp),
    .ahbls_hexokay    (hexokay),
    .ahbls_haddr      (haddr),
    .ahbls_hwrite     (hwrite),
    .ahbls_htrans     (htrans),
    .ahbls_hsize      (hsize),
    .ahbls_hburst     (3'b000),
    .ahbls_hprot      (4'b0011),
    .ahbls_hmastlock  (1'b0),
    .ahbls_hexcl      (hexcl),
    .ahbls_hwdata     (hwdata),
    .ahbls_hrdata     (hrdata),
    .cfg_stall        (cfg_stall),
    .cfg_err          (cfg_err)
  );

  // 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction model: each accepted transfer expands into its list of
  // response cycles; an empty list means a plain zero-wait OKAY.
  // --------------------------------------------------------------------------
  typedef struct {
    bit rdy;
    bit resp;
    bit done;
    bit write;
    bit excl;
    int idx;
    int lo;
    int size;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] mem_m[int];
  bit          res_v;
  int          res_i;

  function automatic entry_t make_entry(bit rdy, bit resp);
    entry_t e;
    e.rdy   = rdy;
    e.resp  = resp;
    e.done  = 1'b0;
    e.write = 1'b0;
    e.excl  = 1'b0;
    e.idx   = 0;
    e.lo    = 0;
    e.size  = 0;
    return e;
  endfunction

  // Compare process: every negedge, take the expected cycle, apply its
  // memory/reservation effects, check the DUT, then expand a new transfer.
  always @(negedge clk) begin
    entry_t      e;
    entry_t      ne;
    bit          exp_exok;
    bit          do_wr;
    bit          bad;
    int          sz;
    logic [31:0] exp_data;
    logic [31:0] word;
    exp_exok = 1'b0;
    exp_data = 32'd0;
    if (!rst_n) begin
      exp_q.delete();
      res_v = 1'b0;
      e = make_entry(1'b1, 1'b0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = make_entry(1'b1, 1'b0);
    end
    if (e.done) begin
      if (e.write) begin
        do_wr = 1'b1;
        if (e.excl) begin
          do_wr    = res_v && (res_i == e.idx);
          exp_exok = do_wr;
          if (do_wr) res_v = 1'b0;
        end else if (res_v && (res_i == e.idx)) begin
          res_v = 1'b0;
        end
        if (do_wr) begin
          word = mem_m.exists(e.idx) ? mem_m[e.idx] : 32'd0;
          for (int b = e.lo; b < e.lo + (1 << e.size); b++) begin
            word[8*b +: 8] = hwdata[8*b +: 8];
          end
          mem_m[e.idx] = word;
        end
      end else begin
        exp_data = mem_m.exists(e.idx) ? mem_m[e.idx] : 32'd0;
        if (e.excl) begin
          res_v    = 1'b1;
          res_i    = e.idx;
          exp_exok = 1'b1;
        end
      end
    end
    checkOutput("model_hready_resp", hready_resp, e.rdy);
    checkOutput("model_hresp", hresp, e.resp);
    checkOutput("model_hexokay", hexokay, exp_exok);
    checkOutput("model_hrdata", hrdata, exp_data);
    if (rst_n && htrans[1] && e.rdy) begin
      sz  = int'(hsize);
      bad = cfg_err || (hsize > 3'd2) || ((haddr % (1 << sz)) != 0) ||
            ((haddr >> 2) >= DEPTH);
      for (int i = 0; i < int'(cfg_stall); i++) exp_q.push_back(make_entry(1'b0, 1'b0));
      if (bad) begin
        exp_q.push_back(make_entry(1'b0, 1'b1));
        exp_q.push_back(make_entry(1'b1, 1'b1));
      end else begin
        ne       = make_entry(1'b1, 1'b0);
        ne.done  = 1'b1;
        ne.write = hwrite;
        ne.excl  = hexcl;
        ne.idx   = int'(haddr >> 2);
        ne.lo    = int'(haddr[1:0]);
        ne.size  = sz;
        exp_q.push_back(ne);
      end
    end
  end

  // One non-pipelined transfer: address phase, then the data phase until the
  // slave signals ready. Reports wait count, whether ERR1 was seen and the
  // final-cycle response.
  task automatic applyStimulus(input logic [31:0] addr, input bit write,
                               input logic [2:0] size, input bit excl,
                               input logic [31:0] wdata, input logic [3:0] stall,
                               input bit err, output int waits, output bit err_seen,
                               output logic fin_resp, output logic [31:0] rd,
                               output logic exok);
    bit done;
    int n;
    haddr     = addr;
    hwrite    = write;
    hsize     = size;
    hexcl     = excl;
    cfg_stall = stall;
    cfg_err   = err;
    htrans    = 2'b10;
    @(posedge clk); #1;
    htrans    = 2'b00;
    hwrite    = 1'b0;
    hexcl     = 1'b0;
    cfg_stall = 4'd0;
    cfg_err   = 1'b0;
    hwdata    = wdata;
    waits     = 0;
    err_seen  = 1'b0;
    fin_resp  = 1'b0;
    rd        = 32'd0;
    exok      = 1'b0;
    done      = 1'b0;
    n         = 0;
    while (!done) begin
      @(negedge clk);
      if (hready_resp) begin
        fin_resp = hresp;
        rd       = hrdata;
        exok     = hexokay;
        done     = 1'b1;
      end else if (hresp) begin
        err_seen = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 40) begin
        checks++;
        errors++;
        $display("[TB] FAIL transfer_timeout: no ready after %0d cycles, expected completion", n);
        done = 1'b1;
      end
    end
  endtask

  // Directed sequence with literal expectations.
  initial begin
    int          waits;
    int          n;
    bit          err_seen;
    bit          rdy_now;
    logic        fin_resp;
    logic [31:0] rd;
    logic        exok;

    rst_n     = 1'b1;
    htrans    = 2'b00;
    haddr     = 32'd0;
    hwrite    = 1'b0;
    hsize     = 3'd2;
    hexcl     = 1'b0;
    hwdata    = 32'd0;
    cfg_stall = 4'd0;
    cfg_err   = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_hready_resp", hready_resp, 32'd1);
    checkOutput("reset_hresp", hresp, 32'd0);
    checkOutput("reset_hexokay", hexokay, 32'd0);
    checkOutput("reset_hrdata", hrdata, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write then read back.
    applyStimulus(32'h10, 1, 3'd2, 0, 32'hA5A5_1234, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("wr10_waits", waits, 32'd0);
    checkOutput("wr10_resp", fin_resp, 32'd0);
    applyStimulus(32'h10, 0, 3'd2, 0, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("rd10_waits", waits, 32'd0);
    checkOutput("rd10_data", rd, 32'hA5A5_1234);

    // Stalled read with the next read already presented on the bus.
    haddr     = 32'h10;
    hwrite    = 1'b0;
    hsize     = 3'd2;
    cfg_stall = 4'd3;
    htrans    = 2'b10;
    @(posedge clk); #1;
    cfg_stall = 4'd0;
    waits     = 0;
    n         = 0;
    rd        = 32'd0;
    do begin
      @(negedge clk);
      rdy_now = hready_resp;
      if (rdy_now) rd = hrdata;
      else waits++;
      @(posedge clk); #1;
      n++;
    end while (!rdy_now && n < 40);
    htrans = 2'b00;
    checkOutput("stall3_waits", waits, 32'd3);
    checkOutput("stall3_data", rd, 32'hA5A5_1234);
    @(negedge clk);
    checkOutput("b2b_hready_resp", hready_resp, 32'd1);
    checkOutput("b2b_data", hrdata, 32'hA5A5_1234);
    @(posedge clk); #1;

    // Forced error after two wait states; memory must be unchanged.
    applyStimulus(32'h10, 1, 3'd2, 0, 32'hDEAD_BEEF, 4'd2, 1, waits, err_seen, fin_resp, rd, exok);
    checkOutput("err_waits", waits, 32'd2);
    checkOutput("err_err1_seen", err_seen, 32'd1);
    checkOutput("err_final_resp", fin_resp, 32'd1);
    applyStimulus(32'h10, 0, 3'd2, 0, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("after_err_data", rd, 32'hA5A5_1234);

    // Exclusive pair succeeds; a repeated store-exclusive fails.
    applyStimulus(32'h20, 1, 3'd2, 0, 32'h1111_2222, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    applyStimulus(32'h20, 0, 3'd2, 1, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("ldex_exokay", exok, 32'd1);
    checkOutput("ldex_data", rd, 32'h1111_2222);
    applyStimulus(32'h20, 1, 3'd2, 1, 32'h3333_4444, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("stex1_exokay", exok, 32'd1);
    applyStimulus(32'h20, 1, 3'd2, 1, 32'h5555_6666, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("stex2_exokay", exok, 32'd0);
    applyStimulus(32'h20, 0, 3'd2, 0, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("stex_result", rd, 32'h3333_4444);

    // Byte and halfword lanes.
    applyStimulus(32'h21, 1, 3'd0, 0, 32'h0000_AB00, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    applyStimulus(32'h22, 1, 3'd1, 0, 32'h7777_0000, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    applyStimulus(32'h20, 0, 3'd2, 0, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("lanes_data", rd, 32'h7777_AB44);

    // Misaligned halfword, out-of-range word, oversized transfer.
    applyStimulus(32'h01, 0, 3'd1, 0, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("misalign_waits", waits, 32'd0);
    checkOutput("misalign_err1", err_seen, 32'd1);
    checkOutput("misalign_resp", fin_resp, 32'd1);
    applyStimulus(DEPTH * 4, 0, 3'd2, 0, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("oob_err1", err_seen, 32'd1);
    checkOutput("oob_resp", fin_resp, 32'd1);
    applyStimulus(32'h00, 0, 3'd3, 0, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("size3_resp", fin_resp, 32'd1);

    // An errored load-exclusive must not set the reservation.
    applyStimulus(32'h20, 0, 3'd2, 1, 32'd0, 4'd0, 1, waits, err_seen, fin_resp, rd, exok);
    checkOutput("ldex_err_resp", fin_resp, 32'd1);
    applyStimulus(32'h20, 1, 3'd2, 1, 32'hCAFE_0000, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("stex_noresv_exokay", exok, 32'd0);

    // A plain write to the reserved word kills the reservation.
    applyStimulus(32'h20, 0, 3'd2, 1, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    applyStimulus(32'h20, 1, 3'd2, 0, 32'h9999_0000, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    applyStimulus(32'h20, 1, 3'd2, 1, 32'h1212_1212, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("stex_killed_exokay", exok, 32'd0);
    applyStimulus(32'h20, 0, 3'd2, 0, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("killed_data", rd, 32'h9999_0000);

    // Reset in the middle of a stalled transfer, with a reservation held.
    applyStimulus(32'h20, 0, 3'd2, 1, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    haddr     = 32'h10;
    hwrite    = 1'b0;
    hsize     = 3'd2;
    cfg_stall = 4'd5;
    htrans    = 2'b10;
    @(posedge clk); #1;
    htrans    = 2'b00;
    cfg_stall = 4'd0;
    @(posedge clk); #1;
    checkOutput("wait_before_reset", hready_resp, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_hready_resp", hready_resp, 32'd1);
    checkOutput("midreset_hresp", hresp, 32'd0);
    checkOutput("midreset_hexokay", hexokay, 32'd0);
    checkOutput("midreset_hrdata", hrdata, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h10, 0, 3'd2, 0, 32'd0, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("post_reset_waits", waits, 32'd0);
    checkOutput("post_reset_data", rd, 32'hA5A5_1234);
    applyStimulus(32'h20, 1, 3'd2, 1, 32'hFFFF_0000, 4'd0, 0, waits, err_seen, fin_resp, rd, exok);
    checkOutput("post_reset_stex", exok, 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_test_slave.md
AHBL_TEST_SLAVE -- requirements
Module: ahbl_test_slave

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, address width.
REQ-002 SHALL have parameter W_DATA, default 32, data width; only 32 supported.
REQ-003 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words; power of 2.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ahbls_hready  in  1  bus HREADY.
- ahbls_hready_resp  out  1  slave HREADYOUT.
- ahbls_hresp  out  1  1 = ERROR.
- ahbls_hexokay  out  1  exclusive-access success.
- ahbls_haddr  in  W_ADDR  address.
- ahbls_hwrite  in  1  write.
- ahbls_htrans  in  2  transfer type.
- ahbls_hsize  in  3  size.
- ahbls_hexcl  in  1  exclusive.
- ahbls_hwdata  in  W_DATA  write data.
- ahbls_hrdata  out  W_DATA  read data.
- cfg_stall  in  4  wait states for the transfer being accepted.
- cfg_err  in  1  force ERROR for the transfer being accepted.
- HBURST, HPROT, HMASTLOCK inputs SHALL exist and SHALL be ignored.

Function
REQ-005 SHALL accept an address phase when ahbls_hready=1 and htrans[1]=1, latching addr, write, size, excl, cfg_stall and cfg_err.
- The final cycle of a data phase SHALL accept the next address phase (back-to-back pipelining).
REQ-006 SHALL flag a transfer as bad if any of the following holds:
- cfg_err=1.
- hsize>2.
- addr not aligned to size.
- word index addr[W_ADDR-1:2] >= DEPTH.
REQ-007 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2.
REQ-008 IDLE: hready_resp=1, hresp=0.
- On accept: go to WAIT if stall>0.
- Else go to ERR1 if bad.
- Else complete immediately on the next cycle (OKAY, hready_resp=1).
REQ-009 WAIT SHALL hold hready_resp=0, hresp=0 for exactly cfg_stall cycles, then enter ERR1 if bad, else produce one OKAY cycle with hready_resp=1.
REQ-010 ERR1 SHALL drive hresp=1, hready_resp=0; ERR2 SHALL drive hresp=1, hready_resp=1. ERR1->ERR2 is unconditional.
REQ-011 A non-accepted cycle (htrans IDLE/BUSY) SHALL yield a zero-wait OKAY in the next cycle.
REQ-012 A write SHALL update memory only on its completing OKAY cycle.
- Byte lanes come from size and addr[1:0].
- Data comes from hwdata sampled in that cycle.
REQ-013 A read SHALL drive hrdata=mem[word] during its completing OKAY cycle; hrdata SHALL be 0 in all other cycles.
REQ-014 SHALL hold one exclusive reservation (valid bit + word index).
REQ-015 Exclusive read completing OKAY SHALL:
- set the reservation to its word;
- drive hexokay=1.
REQ-016 Exclusive write completing OKAY with reservation valid and matching word SHALL:
- perform the write;
- drive hexokay=1;
- clear the reservation.
REQ-017 Exclusive write completing OKAY otherwise SHALL suppress the write and drive hexokay=0.
REQ-018 Any non-exclusive write completing OKAY to the reserved word SHALL clear the reservation.
REQ-019 hexokay SHALL be 0 in all cycles other than the completing cycle of a successful exclusive access.
REQ-020 ERROR-terminated transfers SHALL NOT modify memory or the reservation.

Reset
REQ-021 Reset SHALL force the following, asynchronously, including mid-transfer:
- state=IDLE;
- hready_resp=1, hresp=0, hexokay=0, hrdata=0;
- reservation invalid.
REQ-022 Memory contents SHALL NOT be reset.

Verification
REQ-023 Write 0xA5A5_1234 to 0x10 with cfg_stall=0, then read 0x10 -> OKAY, zero waits, hrdata=0xA5A5_1234.
REQ-024 Read with cfg_stall=3 -> hready_resp low 3 cycles, then high with data; the next address phase is accepted on that cycle.
REQ-025 Write with cfg_err=1, cfg_stall=2 -> 2 wait cycles, then (hresp=1, hready_resp=0), then (1,1); memory unchanged.
REQ-026 Exclusive read of 0x20, then exclusive write 0x20 -> hexokay=1 on both, memory written. A second exclusive write to 0x20 -> hexokay=0, memory unchanged.
REQ-027 Halfword access at 0x01, and access at word index DEPTH -> two-phase ERROR each.
REQ-028 rst_n asserted during WAIT -> outputs at reset values immediately; after release, the next transfer completes normally.
